// File: rtl/block_ram_arb_pkg.sv
// Shared types and defaults for the block RAM arbiter slice.
// State encoding, port indices and default RAM geometry.
package block_ram_arb_pkg;

  localparam int NUM_ENTRIES_DEF = 256;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/block_ram_arbiter_rr_select.sv
// Combinational two-way winner select: locked owner, then round-robin pointer, then the other port.
// Zero latency; o_vld is low only when neither port requests.
module rr_select
  import block_ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_lock,
  input  logic       i_owner,
  output logic       o_vld,
  output logic       o_win
);

  always_comb begin
    o_vld = |i_req;
    o_win = i_ptr;
    if (i_lock && i_req[i_owner]) begin
      o_win = i_owner;
    end else if (i_req[i_ptr]) begin
      o_win = i_ptr;
    end else begin
      o_win = ~i_ptr;
    end
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter and IDLE->ACCESS->RESP sequencer for the single-port block RAM (p0 CPU, p1 debug).
// Ack two cycles after the grant, one access per three cycles; a requester holds its request until ack.
module block_ram_arbiter
  import block_ram_arb_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_lock_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_lock_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [32:0] LP_LIMIT = 33'(NUM_ENTRIES);

  state_e            r_state;
  req_t              r_req;
  logic              r_ptr;
  logic              r_lock_flg;
  logic              r_grant;
  logic              r_oor;
  logic              r_mem_wr;
  logic [1:0]        r_ack;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_req;
  logic              w_win_vld;
  logic              w_win;
  logic              w_sel_oor;
  req_t              w_req0;
  req_t              w_req1;
  req_t              w_sel;
  logic [DATA_W-1:0] w_rd;

  assign w_req     = {p1_req_i, p0_req_i};
  assign w_req0    = '{we: p0_we_i, lock: p0_lock_i, addr: p0_addr_i, wdata: p0_wdata_i};
  assign w_req1    = '{we: p1_we_i, lock: p1_lock_i, addr: p1_addr_i, wdata: p1_wdata_i};
  assign w_sel     = (w_win == PORT_DBG) ? w_req1 : w_req0;
  assign w_sel_oor = (33'(w_sel.addr) >= LP_LIMIT);
  assign w_rd      = r_oor ? '0 : mem_rdata_i;

  // The last-served port is the lock owner.
  rr_select u_rr_select (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .i_lock  (r_lock_flg),
    .i_owner (r_grant),
    .o_vld   (w_win_vld),
    .o_win   (w_win)
  );

  // r_mem_wr is a register with async reset so a reset during ACCESS kills the write before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_ptr      <= PORT_CPU;
      r_lock_flg <= 1'b0;
      r_grant    <= PORT_CPU;
      r_oor      <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_req    <= w_sel;
            r_grant  <= w_win;
            r_oor    <= w_sel_oor;
            r_mem_wr <= w_sel.we & ~w_sel_oor;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_wr <= 1'b0;
          if (!r_req.we) begin
            if (r_grant == PORT_DBG) r_rdata1 <= w_rd;
            else                     r_rdata0 <= w_rd;
          end
          r_ack[r_grant] <= 1'b1;
          r_err[r_grant] <= r_oor;
          r_state        <= RESP;
        end
        RESP: begin
          if (r_req.lock) begin
            r_lock_flg <= 1'b1;
          end else begin
            r_ptr      <= ~r_grant;
            r_lock_flg <= 1'b0;
          end
          r_state <= IDLE;
        end
        default: begin
          r_mem_wr <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign p0_ack_o    = r_ack[0];
  assign p1_ack_o    = r_ack[1];
  assign p0_err_o    = r_err[0];
  assign p1_err_o    = r_err[1];
  assign p0_rdata_o  = r_rdata0;
  assign p1_rdata_o  = r_rdata1;
  assign mem_wr_o    = r_mem_wr;
  assign mem_addr_o  = r_req.addr;
  assign mem_wdata_o = r_req.wdata;
  assign busy_o      = (r_state != IDLE);
  assign grant_o     = r_grant;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed self-checking bench for block_ram_arbiter with a behavioural block RAM model.
module tb_block_ram_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        p0_req, p0_lock, p0_we;
  logic [15:0] p0_addr, p0_wdata;
  logic        p1_req, p1_lock, p1_we;
  logic [15:0] p1_addr, p1_wdata;
  logic        p0_ack_o, p0_err_o, p1_ack_o, p1_err_o;
  logic [15:0] p0_rdata_o, p1_rdata_o;
  logic        mem_wr_o;
  logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o, grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ram [256];
  logic        ram_load;

  bit          got;
  logic        gerr;
  logic [15:0] grd;

  block_ram_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .p0_req_i    (p0_req),
    .p0_lock_i   (p0_lock),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_ack_o    (p0_ack_o),
    .p0_err_o    (p0_err_o),
    .p0_rdata_o  (p0_rdata_o),
    .p1_req_i    (p1_req),
    .p1_lock_i   (p1_lock),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_ack_o    (p1_ack_o),
    .p1_err_o    (p1_err_o),
    .p1_rdata_o  (p1_rdata_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .grant_o     (grant_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // RAM model: reset image on ram_load, write commits on the clock edge, combinational read.
  always @(posedge clk_i) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
      ram[0] <= 16'h5A5A;
      ram[3] <= 16'hAAAA;
      ram[5] <= 16'h1234;
    end else if (mem_wr_o) begin
      ram[mem_addr_o[7:0]] <= mem_wdata_o;
    end
  end
  assign mem_rdata_i = ram[mem_addr_o[7:0]];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one unlocked access from an IDLE cycle; returns in the IDLE cycle after the ack.
  task automatic access(input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, output bit ok, output logic err,
                        output logic [15:0] rd);
    ok  = 1'b0;
    err = 1'bx;
    rd  = 16'hxxxx;
    if (port) begin
      p1_req = 1'b1; p1_lock = 1'b0; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_lock = 1'b0; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (port ? p1_ack_o : p0_ack_o) begin
        ok  = 1'b1;
        err = port ? p1_err_o : p0_err_o;
        rd  = port ? p1_rdata_o : p0_rdata_o;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; ram_load = 1'b1;
    p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    repeat (2) tick();
    ram_load = 1'b0;

    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_ack", {p1_ack_o, p0_ack_o, p1_err_o, p0_err_o}, 0);
    check("rst_rdata0", p0_rdata_o, 0);
    check("rst_rdata1", p1_rdata_o, 0);
    check("rst_mem", {mem_wr_o, mem_addr_o, mem_wdata_o}, 0);
    rst_i = 1'b0;

    // p0 write then read of 0x0010
    p0_req = 1; p0_we = 1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    check("t1_c0_wr", mem_wr_o, 0);
    tick();
    check("t1_c1_wr", mem_wr_o, 1);
    check("t1_c1_addr", mem_addr_o, 16'h0010);
    check("t1_c1_wdata", mem_wdata_o, 16'hBEEF);
    check("t1_c1_busy", busy_o, 1);
    check("t1_c1_ack", p0_ack_o, 0);
    tick();
    check("t1_c2_ack", p0_ack_o, 1);
    check("t1_c2_err", p0_err_o, 0);
    check("t1_c2_wr", mem_wr_o, 0);
    p0_req = 0;
    tick();
    check("t1_c3_ack", p0_ack_o, 0);
    check("t1_c3_busy", busy_o, 0);
    check("t1_c3_wdata_held", mem_wdata_o, 16'hBEEF);
    access(0, 0, 16'h0010, 16'h0, got, gerr, grd);
    check("t1_rd_ack", got, 1);
    check("t1_rd_err", gerr, 0);
    check("t1_rd_data", grd, 16'hBEEF);

    // out-of-range write and read at 0x0100
    p0_req = 1; p0_we = 1; p0_addr = 16'h0100; p0_wdata = 16'hCAFE;
    tick();
    check("t4_c1_wr", mem_wr_o, 0);
    check("t4_c1_addr", mem_addr_o, 16'h0100);
    tick();
    check("t4_c2_ack", p0_ack_o, 1);
    check("t4_c2_err", p0_err_o, 1);
    check("t4_c2_wr", mem_wr_o, 0);
    p0_req = 0;
    tick();
    check("t4_ram0", ram[0], 16'h5A5A);
    access(0, 0, 16'h0100, 16'h0, got, gerr, grd);
    check("t4_rd_ack", got, 1);
    check("t4_rd_err", gerr, 1);
    check("t4_rd_data", grd, 16'h0000);

    // p0 read, then p1 write must not disturb p0 outputs
    access(0, 0, 16'h0003, 16'h0, got, gerr, grd);
    check("t6_rd_ack", got, 1);
    check("t6_rd_data", grd, 16'hAAAA);
    p1_req = 1; p1_we = 1; p1_addr = 16'h0020; p1_wdata = 16'h7777;
    tick();
    tick();
    check("t6_p1_ack", p1_ack_o, 1);
    check("t6_p0_ack", p0_ack_o, 0);
    check("t6_p0_err", p0_err_o, 0);
    check("t6_p0_rdata", p0_rdata_o, 16'hAAAA);
    check("t6_p1_rdata", p1_rdata_o, 16'h0000);
    p1_req = 0;
    tick();
    check("t6_p0_rdata_after", p0_rdata_o, 16'hAAAA);
    access(1, 0, 16'h0020, 16'h0, got, gerr, grd);
    check("t6_p1_rd_ack", got, 1);
    check("t6_p1_rd_data", grd, 16'h7777);

    // both ports read continuously, unlocked: strict alternation starting at p0
    p0_req = 1; p0_we = 0; p0_lock = 0; p0_addr = 16'h0003;
    p1_req = 1; p1_we = 0; p1_lock = 0; p1_addr = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t2_busy_%0d", k), busy_o, (k % 3) != 0);
      check($sformatf("t2_ack0_%0d", k), p0_ack_o, (k % 6) == 2);
      check($sformatf("t2_ack1_%0d", k), p1_ack_o, (k % 6) == 5);
      if (k >= 1) check($sformatf("t2_grant_%0d", k), grant_o, ((k - 1) / 3) % 2);
      if (k == 11) begin p0_req = 0; p1_req = 0; end
      tick();
    end
    check("t2_rdata0", p0_rdata_o, 16'hAAAA);
    check("t2_rdata1", p1_rdata_o, 16'hBEEF);

    // p1 locked for three accesses while p0 waits, then pointer hands over to p1
    p1_req = 1; p1_we = 0; p1_lock = 1; p1_addr = 16'h0005;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("t3_ack1_%0d", k), p1_ack_o, (k == 2 || k == 5 || k == 8 || k == 14));
      check($sformatf("t3_ack0_%0d", k), p0_ack_o, k == 11);
      check($sformatf("t3_busy_%0d", k), busy_o, (k % 3) != 0);
      if (k >= 1) check($sformatf("t3_grant_%0d", k), grant_o, (k >= 10 && k <= 12) ? 0 : 1);
      if (k == 1)  begin p0_req = 1; p0_we = 0; p0_addr = 16'h0003; end
      if (k == 8)  p1_req = 0;
      if (k == 11) begin p1_req = 1; p1_lock = 0; end
      if (k == 14) begin p0_req = 0; p1_req = 0; end
      tick();
    end
    check("t3_rdata1", p1_rdata_o, 16'h1234);

    // reset during the ACCESS of a p0 write to 0x0005
    p0_req = 1; p0_we = 1; p0_addr = 16'h0005; p0_wdata = 16'hDEAD;
    tick();
    check("t5_c1_wr", mem_wr_o, 1);
    #1 rst_i = 1'b1;
    #1;
    check("t5_rst_wr", mem_wr_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_addr", mem_addr_o, 16'h0000);
    check("t5_rst_wdata", mem_wdata_o, 16'h0000);
    check("t5_rst_rdata0", p0_rdata_o, 16'h0000);
    check("t5_rst_rdata1", p1_rdata_o, 16'h0000);
    p0_req = 0;
    tick();
    rst_i = 1'b0;
    check("t5_ram5", ram[5], 16'h1234);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_noack_%0d", k), {p0_ack_o, p1_ack_o}, 0);
      tick();
    end
    access(0, 0, 16'h0005, 16'h0, got, gerr, grd);
    check("t5_rd_ack", got, 1);
    check("t5_rd_err", gerr, 0);
    check("t5_rd_data", grd, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_ram_arbiter.md
# block_ram_arbiter

Two-requester round-robin arbiter and access sequencer for the single-port 16-bit block RAM, which has a combinational read and a write that commits on the clock edge. It sits between the RAM and two masters: port 0 is the CPU data side, port 1 is the debug/loader side. Each access is serialised through a fixed 3-state sequence. The block returns registered read data, a one-cycle ack and an out-of-range error flag to the requester.

## Interface
- NUM_ENTRIES, 256, RAM depth; addresses >= NUM_ENTRIES are errors
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- pN_req_i  in  1  port N (N=0,1) request; addr/we/wdata/lock held stable until ack
- pN_lock_i  in  1  keep ownership for this port's next request
- pN_we_i  in  1  1=write, 0=read
- pN_addr_i  in  ADDR_W  word address
- pN_wdata_i  in  DATA_W  write data
- pN_ack_o  out  1  one-cycle completion pulse
- pN_err_o  out  1  valid with ack; address out of range
- pN_rdata_o  out  DATA_W  read result, valid from ack, held until next read ack on that port
- mem_wr_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM combinational read data
- busy_o  out  1  state != IDLE
- grant_o  out  1  index of the port currently or last served

## Operation
- States: IDLE -> ACCESS -> RESP -> IDLE. There are no other transitions.
- IDLE, no request: the block stays in IDLE.
- IDLE, one or both requests: select the winner.
  - The owner wins if the lock flag is set and the owner requests.
  - Otherwise the port at the round-robin pointer wins if it requests.
  - Otherwise the other port wins.
  - Latch the winner's we/addr/wdata/lock and its index into grant_o, then go to ACCESS.
- ACCESS:
  - mem_addr_o and mem_wdata_o are driven from the latches.
  - mem_wr_o = latched_we AND (addr < NUM_ENTRIES).
  - On a read with a valid address, capture mem_rdata_i into the winner's rdata register.
  - Out-of-range read: rdata register is loaded with 0 and the error is flagged.
  - Out-of-range write: no RAM write; the error is flagged.
  - Next state is RESP.
- RESP:
  - Winner's ack_o = 1 and err_o = out-of-range flag, for this cycle only.
  - Pointer update: if the latched lock is 0, the pointer becomes the other port and the lock flag clears. If lock is 1, the pointer is unchanged and the lock flag is set.
  - Next state is IDLE.
- A request still high during its ack cycle counts as a new request at the next IDLE.
- A write ack leaves rdata_o unchanged.
- The loser's ack/err/rdata are untouched.
- mem_wr_o is 0 in IDLE and RESP. mem_addr_o and mem_wdata_o hold their latched values outside ACCESS.

## Timing
- Request seen high in IDLE at cycle 0:
  - ACCESS in cycle 1; a RAM write commits at the end of cycle 1.
  - ack in cycle 2.
  - Earliest next grant decision in cycle 3.
- Throughput is one access per 3 cycles.
- A read after a write to the same address, on either port, returns the new data.
- Reset values: state IDLE, pointer 0, lock flag 0, grant_o 0, busy_o 0, all ack/err 0, all rdata_o 0, mem_wr_o 0, mem_addr_o 0, mem_wdata_o 0.
- Reset mid-ACCESS: mem_wr_o drops asynchronously and no write commits. No ack is ever issued for the aborted access; the requester must re-request.
- Reset mid-RESP: ack drops immediately.
- Simultaneous requests with lock clear alternate strictly: 0, 1, 0, 1, ...
- A locked owner that stops requesting loses priority. The other port wins, and the lock flag clears when that access completes.

## Structure
- Package block_ram_arb_pkg: the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port index constants PORT_CPU=0 and PORT_DBG=1, and the default widths.
- The single natural sub-module is rr_select: a combinational winner select from req[1:0], pointer and lock flag/owner. It is kept separate for unit test.
- The remainder is one FSM with request latches and per-port output registers.

## Test plan
- Reset, then p0 write addr 0x0010 data 0xBEEF, then p0 read addr 0x0010:
  - First ack is in cycle 2 with mem_wr_o=1 in cycle 1 only.
  - The read returns rdata 0xBEEF with err 0.
- Both ports request reads every cycle, lock 0:
  - Grants are 0, 1, 0, 1.
  - Each ack comes exactly 3 cycles apart.
  - busy_o stays 1 except in the IDLE cycles.
- p1 holds lock=1 for 3 back-to-back requests while p0 requests continuously:
  - p1 is served 3 times, then p0 is served.
  - The pointer then points to p0's opposite, i.e. p1.
- p0 write addr 0x0100 (NUM_ENTRIES=256):
  - mem_wr_o stays 0 throughout.
  - ack with err=1.
  - A subsequent read of 0x0100 gives err=1 and rdata 0x0000.
- Assert rst_i during the ACCESS of a p0 write to 0x0005 (old value 0x1234):
  - All outputs return to reset values and no ack is issued.
  - A later read of 0x0005 returns 0x1234.
  - Compare against the RAM model including its own reset image.
- p0 read of 0x0003 yields 0xAAAA; then a p1 write completes:
  - p0_rdata_o still reads 0xAAAA.
  - p0_ack_o and p0_err_o stay 0 during p1's ack.
